// File: rtl/la_seq_pkg.sv
// Shared constants, LA field layout, opcode set and state encoding for the LA command sequencer.
package la_seq_pkg;

    localparam int unsigned LA_W   = 64;
    localparam int unsigned IO_W   = 16;
    localparam int unsigned OPND_W = 32;
    localparam int unsigned OPC_W  = 4;
    localparam int unsigned ACK_W  = 4;

    // LA input field positions
    localparam int unsigned OPND_LSB = 0;
    localparam int unsigned OPND_MSB = 31;
    localparam int unsigned OPC_LSB  = 32;
    localparam int unsigned OPC_MSB  = 35;
    localparam int unsigned STB_BIT  = 36;

    // Status word bit positions
    localparam int unsigned ST_ACK_LSB   = 0;
    localparam int unsigned ST_ACK_MSB   = 3;
    localparam int unsigned ST_WRAP_BIT  = 4;
    localparam int unsigned ST_ERR_BIT   = 5;
    localparam int unsigned ST_STATE_LSB = 6;
    localparam int unsigned ST_STATE_MSB = 7;
    localparam int unsigned ST_TAG_LSB   = 8;
    localparam int unsigned ST_TAG_MSB   = 15;

    // Opcodes; 7..15 are illegal
    localparam logic [OPC_W-1:0] OP_NOP   = 4'd0;
    localparam logic [OPC_W-1:0] OP_LOAD  = 4'd1;
    localparam logic [OPC_W-1:0] OP_LIMIT = 4'd2;
    localparam logic [OPC_W-1:0] OP_RUN   = 4'd3;
    localparam logic [OPC_W-1:0] OP_STOP  = 4'd4;
    localparam logic [OPC_W-1:0] OP_STEP  = 4'd5;
    localparam logic [OPC_W-1:0] OP_CLEAR = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Captured command payload
    typedef struct packed {
        logic [OPC_W-1:0]  opc;
        logic [OPND_W-1:0] opnd;
    } la_cmd_t;

    // Opcode is inside the defined set
    function automatic logic op_legal(input logic [OPC_W-1:0] opc);
        return (opc <= OP_CLEAR);
    endfunction

    // Opcode may be accepted while the counter is running
    function automatic logic op_run_ok(input logic [OPC_W-1:0] opc);
        return (opc == OP_NOP) || (opc == OP_STOP) || (opc == OP_CLEAR);
    endfunction

endpackage

// File: rtl/la_cmd_capture.sv
// Registers the LA command fields and detects a qualified strobe toggle.
module la_cmd_capture
    import la_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [STB_BIT:0]  la_data,
    input  logic [STB_BIT:0]  la_oenb,
    output logic              cmd_valid_c,
    output logic [OPC_W-1:0]  cmd_opc,
    output logic [OPND_W-1:0] cmd_opnd
);

    la_cmd_t cmd_q;
    logic    strobe_q;
    logic    strobe_qq;
    logic    oenb_ok_q;

    // Capture command, strobe history and whether mgmt owned every command bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q     <= '0;
            strobe_q  <= 1'b0;
            strobe_qq <= 1'b0;
            oenb_ok_q <= 1'b0;
        end else begin
            cmd_q.opc  <= la_data[OPC_MSB:OPC_LSB];
            cmd_q.opnd <= la_data[OPND_MSB:OPND_LSB];
            strobe_q   <= la_data[STB_BIT];
            strobe_qq  <= strobe_q;
            oenb_ok_q  <= (la_oenb == '0);
        end
    end

    // A toggle is a command only if the LA bits were driven by mgmt when captured
    assign cmd_valid_c = (strobe_q != strobe_qq) && oenb_ok_q;
    assign cmd_opc     = cmd_q.opc;
    assign cmd_opnd    = cmd_q.opnd;

endmodule

// File: rtl/la_cmd_sequencer.sv
// LA-controlled command sequencer: executes firmware commands on a 32-bit counter
// and publishes a status word on GPIO and LA.
module la_cmd_sequencer
    import la_seq_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter logic [7:0]  TAG   = 8'hAB
) (
    input  logic            wb_clk_i,
    input  logic            wb_rstn_i,
    input  logic [LA_W-1:0] la_data_in,
    input  logic [LA_W-1:0] la_oenb,
    output logic [LA_W-1:0] la_data_out,
    output logic [IO_W-1:0] io_out,
    output logic [IO_W-1:0] io_oeb,
    output logic            irq
);

    logic              cmd_valid_c;
    logic [OPC_W-1:0]  cmd_opc;
    logic [OPND_W-1:0] cmd_opnd;

    state_t            state_q, state_n;
    logic [CNT_W-1:0]  count_q, count_n;
    logic [CNT_W-1:0]  limit_q, limit_n;
    logic              err_q, err_n;
    logic              wrap_q, wrap_n;
    logic [ACK_W-1:0]  ack_q, ack_n;
    logic              irq_q, irq_n;
    logic [IO_W-1:0]   io_oeb_q;
    logic [CNT_W:0]    count_inc;
    logic              halt;
    logic [IO_W-1:0]   status;
    logic              unused_la;

    la_cmd_capture u_capture (
        .clk         (wb_clk_i),
        .rst_n       (wb_rstn_i),
        .la_data     (la_data_in[STB_BIT:0]),
        .la_oenb     (la_oenb[STB_BIT:0]),
        .cmd_valid_c (cmd_valid_c),
        .cmd_opc     (cmd_opc),
        .cmd_opnd    (cmd_opnd)
    );

    // Increment with carry-out; carry marks a wrap from all-ones
    assign count_inc = {1'b0, count_q} + (CNT_W + 1)'(1);

    // State and datapath registers
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            limit_q  <= '0;
            err_q    <= 1'b0;
            wrap_q   <= 1'b0;
            ack_q    <= '0;
            irq_q    <= 1'b0;
            io_oeb_q <= '1;
        end else begin
            state_q  <= state_n;
            count_q  <= count_n;
            limit_q  <= limit_n;
            err_q    <= err_n;
            wrap_q   <= wrap_n;
            ack_q    <= ack_n;
            irq_q    <= irq_n;
            io_oeb_q <= '0;
        end
    end

    // Command execution followed by the run rule; STOP/CLEAR pre-empt the limit check
    always_comb begin
        state_n = state_q;
        count_n = count_q;
        limit_n = limit_q;
        err_n   = err_q;
        wrap_n  = wrap_q;
        ack_n   = ack_q;
        irq_n   = 1'b0;
        halt    = 1'b0;

        if (cmd_valid_c) begin
            if (!op_legal(cmd_opc) || ((state_q == ST_RUN) && !op_run_ok(cmd_opc))) begin
                err_n = 1'b1;
            end else begin
                ack_n = ack_q + ACK_W'(1);
                case (cmd_opc)
                    OP_LOAD: begin
                        count_n = CNT_W'(cmd_opnd);
                        state_n = ST_IDLE;
                    end
                    OP_LIMIT: begin
                        limit_n = CNT_W'(cmd_opnd);
                        state_n = ST_IDLE;
                    end
                    OP_RUN: begin
                        state_n = ST_RUN;
                    end
                    OP_STOP: begin
                        state_n = ST_IDLE;
                        halt    = 1'b1;
                    end
                    OP_STEP: begin
                        count_n = count_inc[CNT_W-1:0];
                        state_n = ST_IDLE;
                        if (count_inc[CNT_W]) wrap_n = 1'b1;
                    end
                    OP_CLEAR: begin
                        count_n = '0;
                        err_n   = 1'b0;
                        wrap_n  = 1'b0;
                        state_n = ST_IDLE;
                        halt    = 1'b1;
                    end
                    default: ;
                endcase
            end
        end

        if ((state_q == ST_RUN) && !halt) begin
            if (count_q == limit_q) begin
                state_n = ST_DONE;
                irq_n   = 1'b1;
            end else begin
                count_n = count_inc[CNT_W-1:0];
                if (count_inc[CNT_W]) wrap_n = 1'b1;
            end
        end
    end

    // Status word assembled from registered fields
    always_comb begin
        status                             = '0;
        status[ST_TAG_MSB:ST_TAG_LSB]      = TAG;
        status[ST_STATE_MSB:ST_STATE_LSB]  = state_q;
        status[ST_ERR_BIT]                 = err_q;
        status[ST_WRAP_BIT]                = wrap_q;
        status[ST_ACK_MSB:ST_ACK_LSB]      = ack_q;
    end

    assign io_out      = status;
    assign io_oeb      = io_oeb_q;
    assign irq         = irq_q;
    assign la_data_out = LA_W'({status, count_q});

    // Upper LA bits carry nothing for this block
    assign unused_la = ^{la_data_in[LA_W-1:STB_BIT+1], la_oenb[LA_W-1:STB_BIT+1]};

endmodule

// File: tb/tb_la_cmd_sequencer.sv
// Directed bench for la_cmd_sequencer with hand-computed expectations.
module tb_la_cmd_sequencer;

    logic        clk;
    logic        wb_rstn_i;
    logic [63:0] la_data_in;
    logic [63:0] la_oenb;
    logic [63:0] la_data_out;
    logic [15:0] io_out;
    logic [15:0] io_oeb;
    logic        irq;
    logic        stb;
    int          vectors;
    int          miscompares;

    la_cmd_sequencer dut (
        .wb_clk_i    (clk),
        .wb_rstn_i   (wb_rstn_i),
        .la_data_in  (la_data_in),
        .la_oenb     (la_oenb),
        .la_data_out (la_data_out),
        .io_out      (io_out),
        .io_oeb      (io_oeb),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Status word plus the full LA readback it implies
    task automatic chk_st(input string tag, input logic [15:0] st, input logic [31:0] cnt);
        chk({tag, " io_out"}, 64'(io_out), 64'(st));
        chk({tag, " la_data_out"}, la_data_out, {16'h0000, st, cnt});
    endtask

    // Present a command with a strobe toggle, then advance one cycle
    task automatic send(input logic [3:0] opc, input logic [31:0] opnd);
        stb        = ~stb;
        la_data_in = {27'd0, stb, opc, opnd};
        @(negedge clk);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        wb_rstn_i  = 1'b0;
        stb        = 1'b0;
        la_data_in = '0;
        la_oenb    = '0;
        @(negedge clk);
        @(negedge clk);
        wb_rstn_i = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        wb_rstn_i   = 1'b0;
        stb         = 1'b0;
        la_data_in  = '0;
        la_oenb     = '0;
        @(negedge clk);
        do_reset();

        // Reset values before and after the first edge
        chk("rst io_oeb", 64'(io_oeb), 64'hFFFF);
        chk_st("rst", 16'hAB00, 32'd0);
        chk("rst irq", 64'(irq), 64'd0);
        cycles(1);
        chk("oeb released", 64'(io_oeb), 64'h0000);
        chk_st("idle", 16'hAB00, 32'd0);

        // LOAD 5, LIMIT 8, RUN on consecutive cycles
        send(4'd1, 32'd5);
        send(4'd2, 32'd8);
        send(4'd3, 32'd0);
        cycles(1); chk_st("run c5", 16'hAB43, 32'd5);
        cycles(1); chk_st("run c6", 16'hAB43, 32'd6);
        cycles(1); chk_st("run c7", 16'hAB43, 32'd7);
        cycles(1); chk_st("run c8", 16'hAB43, 32'd8);
        chk("irq pre-done", 64'(irq), 64'd0);
        cycles(1); chk_st("done", 16'hAB83, 32'd8);
        chk("irq pulse", 64'(irq), 64'd1);
        cycles(1); chk("irq single", 64'(irq), 64'd0);
        chk_st("done hold", 16'hAB83, 32'd8);

        // Wrap through all-ones
        do_reset();
        send(4'd1, 32'hFFFF_FFFE);
        send(4'd2, 32'd1);
        send(4'd3, 32'd0);
        cycles(1); chk_st("wrap fe", 16'hAB43, 32'hFFFF_FFFE);
        cycles(1); chk_st("wrap ff", 16'hAB43, 32'hFFFF_FFFF);
        cycles(1); chk_st("wrap 0", 16'hAB53, 32'd0);
        cycles(1); chk_st("wrap 1", 16'hAB53, 32'd1);
        cycles(1); chk_st("wrap done", 16'hAB93, 32'd1);
        chk("wrap irq", 64'(irq), 64'd1);

        // Rejected and illegal commands during RUN, then CLEAR
        do_reset();
        send(4'd2, 32'd1000);
        send(4'd3, 32'd0);
        cycles(1); chk_st("run2 start", 16'hAB42, 32'd0);
        send(4'd1, 32'd7);
        send(4'd9, 32'd0);
        chk_st("load rejected", 16'hAB62, 32'd2);
        cycles(1); chk_st("illegal op", 16'hAB62, 32'd3);
        send(4'd6, 32'd0);
        chk_st("pre clear", 16'hAB62, 32'd4);
        cycles(1); chk_st("clear", 16'hAB03, 32'd0);

        // Toggle ignored while mgmt does not own the strobe bit
        la_oenb = 64'h0000_0010_0000_0000;
        send(4'd1, 32'h55);
        cycles(1); chk_st("oenb gated", 16'hAB03, 32'd0);
        la_oenb = '0;
        send(4'd1, 32'h55);
        cycles(1); chk_st("oenb open", 16'hAB04, 32'h55);

        // STEP in IDLE ignores the limit
        send(4'd2, 32'h55);
        send(4'd5, 32'd0);
        cycles(1); chk_st("step at limit", 16'hAB06, 32'h56);

        // STOP executing on the edge where count reaches the limit
        do_reset();
        send(4'd2, 32'd100);
        send(4'd3, 32'd0);
        cycles(1); chk_st("run3 start", 16'hAB42, 32'd0);
        cycles(99); chk_st("run3 c99", 16'hAB42, 32'd99);
        send(4'd4, 32'd0);
        chk_st("run3 c100", 16'hAB42, 32'd100);
        cycles(1); chk_st("stop wins", 16'hAB03, 32'd100);
        chk("stop no irq", 64'(irq), 64'd0);
        cycles(1); chk("stop no irq later", 64'(irq), 64'd0);

        // RUN with count already at limit: DONE one cycle later
        send(4'd3, 32'd0);
        cycles(1); chk_st("run at limit", 16'hAB44, 32'd100);
        cycles(1); chk_st("limit done", 16'hAB84, 32'd100);
        chk("limit irq", 64'(irq), 64'd1);

        // Async reset while irq is high
        #2 wb_rstn_i = 1'b0;
        #1;
        chk("areset irq", 64'(irq), 64'd0);
        chk("areset oeb", 64'(io_oeb), 64'hFFFF);
        chk_st("areset done", 16'hAB00, 32'd0);

        // Async reset mid-RUN
        do_reset();
        send(4'd2, 32'd50);
        send(4'd3, 32'd0);
        cycles(3); chk_st("run4 c2", 16'hAB42, 32'd2);
        #2 wb_rstn_i = 1'b0;
        #1;
        chk_st("areset run", 16'hAB00, 32'd0);
        chk("areset run oeb", 64'(io_oeb), 64'hFFFF);
        chk("areset run irq", 64'(irq), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
